// File: rtl/mips_pkg.sv
// Shared register-file types for the MIPS datapath: widths, the zero register, writeback entry.
package mips_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries: up to two pushes and one pop per cycle.
// Contents are exposed oldest-first (slot 0 = head) for Pending decode and bypass search.
module wb_fifo
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push_a,
  input  wb_entry_t        ent_a,
  input  logic             push_b,
  input  wb_entry_t        ent_b,
  input  logic             pop,
  output wb_entry_t        head,
  output logic [CNT_W-1:0] count,
  output logic [DEPTH-1:0] valid,
  output wb_entry_t        entries [DEPTH]
);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [PTR_W-1:0] wr_ptr_b;

  // push_b is only ever raised together with push_a, so it lands one slot after it.
  assign wr_ptr_b = wr_ptr_q + PTR_W'(1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PTR_W'(push_a) + PTR_W'(push_b);
      rd_ptr_q <= rd_ptr_q + PTR_W'(pop);
      count_q  <= count_q + CNT_W'(push_a) + CNT_W'(push_b) - CNT_W'(pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (push_a) mem_q[wr_ptr_q] <= ent_a;
    if (push_b) mem_q[wr_ptr_b] <= ent_b;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [PTR_W-1:0] idx;
    assign idx        = rd_ptr_q + PTR_W'(i);
    assign entries[i] = mem_q[idx];
    assign valid[i]   = CNT_W'(i) < count_q;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

  count_bound: assert property (@(posedge CLK) disable iff (RST) count_q <= CNT_W'(DEPTH));

endmodule

// File: rtl/reg_writeback.sv
// Register-file write-side controller: arbitrates ALU/MEM results into a queue and drains one
// write per cycle. Defining WB_BYPASS_EN adds a combinational forwarding lookup (Q_Addr/Hit).
module reg_writeback
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = REG_DATA_W,
  parameter int unsigned ADDR_W = REG_ADDR_W
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   ALU_Valid,
  output logic                   ALU_Ready,
  input  logic [ADDR_W-1:0]      ALU_Addr,
  input  logic [DATA_W-1:0]      ALU_Data,
  input  logic                   MEM_Valid,
  output logic                   MEM_Ready,
  input  logic [ADDR_W-1:0]      MEM_Addr,
  input  logic [DATA_W-1:0]      MEM_Data,
  output logic [ADDR_W-1:0]      W_Addr,
  output logic [DATA_W-1:0]      W_Data,
  output logic                   WE,
  output logic [31:0]            Pending,
  output logic [$clog2(DEPTH):0] Count
`ifdef WB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0]      Q_Addr,
  output logic                   Hit,
  output logic [DATA_W-1:0]      Hit_Data
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] free;
  wb_entry_t        head;
  wb_entry_t        ent_mem;
  wb_entry_t        ent_alu;
  wb_entry_t        ent_a;
  wb_entry_t        entries [DEPTH];
  logic [DEPTH-1:0] valid;
  logic             mem_push;
  logic             alu_push;
  logic             push_a;
  logic             push_b;
  logic             pop;

  // Same-cycle pop is deliberately ignored so Ready never depends on the drain path.
  assign free = CNT_W'(DEPTH) - count;

  always_comb begin
    ALU_Ready = 1'b0;
    MEM_Ready = 1'b0;
    if (!RST) begin
      if (free >= CNT_W'(2)) begin
        ALU_Ready = 1'b1;
        MEM_Ready = 1'b1;
      end else if (free == CNT_W'(1)) begin
        MEM_Ready = 1'b1;
        ALU_Ready = !MEM_Valid;
      end
    end
  end

  assign ent_mem  = '{addr: MEM_Addr, data: MEM_Data};
  assign ent_alu  = '{addr: ALU_Addr, data: ALU_Data};
  assign mem_push = MEM_Valid && MEM_Ready && (MEM_Addr != REG_ZERO);
  assign alu_push = ALU_Valid && ALU_Ready && (ALU_Addr != REG_ZERO);
  assign push_a   = mem_push || alu_push;
  assign ent_a    = mem_push ? ent_mem : ent_alu;
  assign push_b   = mem_push && alu_push;
  assign pop      = count != '0;

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .CLK    (CLK),
    .RST    (RST),
    .push_a (push_a),
    .ent_a  (ent_a),
    .push_b (push_b),
    .ent_b  (ent_alu),
    .pop    (pop),
    .head   (head),
    .count  (count),
    .valid  (valid),
    .entries(entries)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      WE     <= 1'b0;
      W_Addr <= '0;
      W_Data <= '0;
    end else if (pop) begin
      WE     <= 1'b1;
      W_Addr <= head.addr;
      W_Data <= head.data;
    end else begin
      WE <= 1'b0;
    end
  end

  always_comb begin
    Pending = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (valid[i]) Pending[entries[i].addr] = 1'b1;
    end
    if (WE) Pending[W_Addr] = 1'b1;
    Pending[0] = 1'b0;
  end

  assign Count = count;

`ifdef WB_BYPASS_EN
  // Oldest to youngest, so the last match (tail side) overrides the W stage.
  always_comb begin
    Hit      = 1'b0;
    Hit_Data = '0;
    if (Q_Addr != REG_ZERO) begin
      if (WE && (W_Addr == Q_Addr)) begin
        Hit      = 1'b1;
        Hit_Data = W_Data;
      end
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (valid[i] && (entries[i].addr == Q_Addr)) begin
          Hit      = 1'b1;
          Hit_Data = entries[i].data;
        end
      end
    end
  end
`endif

endmodule
